// File: rtl/input_conditioner.sv
// Button/switch conditioner: 2-flop synchronizer, shared sample tick, per-bit
// saturating debounce counter, and one-cycle rise/fall pulses.
module input_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int SW = $clog2(SAMPLE_CNT_MAX);
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] PULSE_FULL  = CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] level_d_reg;
  logic [SW-1:0]    sample_cnt_reg;
  logic [SW-1:0]    sample_cnt_next;
  logic             sample_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= in_raw;
      sync_reg <= meta_reg;
    end
  end

  // One tick every SAMPLE_CNT_MAX cycles, on the last count before wrap.
  assign sample_tick     = (sample_cnt_reg == SAMPLE_LAST);
  assign sample_cnt_next = sample_tick ? '0 : sample_cnt_reg + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt_reg <= '0;
    end else begin
      sample_cnt_reg <= sample_cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;

      // Any low sample restarts the run; a full run saturates.
      always_comb begin
        cnt_next = cnt_reg;
        if (sample_tick) begin
          if (!sync_reg[gi]) begin
            cnt_next = '0;
          end else if (cnt_reg != PULSE_FULL) begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign level_out[gi] = (cnt_reg == PULSE_FULL);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      level_d_reg <= '0;
    end else begin
      level_d_reg <= level_out;
    end
  end

  assign rise_pulse = level_out & ~level_d_reg;
  assign fall_pulse = ~level_out & level_d_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_raw;
  logic [3:0] level_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH         (4),
    .SAMPLE_CNT_MAX(4),
    .PULSE_CNT_MAX (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_raw    (in_raw),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  typedef struct {
    logic [3:0] in;
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise_cnt;
    int fall_cnt;
    int dropped;
    int seen_high;
    int waited;

    // Timing reference: ticks land on edges 4,8,12,... after reset release,
    // and the synchronizer adds two edges between in_raw and the sampled value.
    vecs[0]  = '{4'b0001, 11, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0001,  1, 4'b0001, 4'b0001, 4'b0000};
    vecs[2]  = '{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0001, 10, 4'b0001, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0000,  4, 4'b0001, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0001};
    vecs[6]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b1001, 10, 4'b0000, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b1001,  1, 4'b1001, 4'b1001, 4'b0000};
    vecs[9]  = '{4'b1001,  1, 4'b1001, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0000,  2, 4'b1001, 4'b0000, 4'b0000};
    vecs[11] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b1001};
    vecs[12] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000};

    rst    = 1'b1;
    in_raw = 4'b0000;
    repeat (3) tick_sample();
    check("reset level", level_out, 4'b0000);
    check("reset rise", rise_pulse, 4'b0000);
    check("reset fall", fall_pulse, 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      in_raw = vecs[i].in;
      repeat (vecs[i].cyc) tick_sample();
      $display("vec %0d in=%b level=%b rise=%b fall=%b", i, vecs[i].in, level_out, rise_pulse, fall_pulse);
      check($sformatf("vec%0d level", i), level_out, vecs[i].lvl);
      check($sformatf("vec%0d rise", i), rise_pulse, vecs[i].rise);
      check($sformatf("vec%0d fall", i), fall_pulse, vecs[i].fall);
    end

    // Bounce on bit 1; phase puts the low half of the toggle on every tick.
    for (int k = 0; k < 100; k++) begin
      in_raw = {2'b00, k[0], 1'b0};
      tick_sample();
      check($sformatf("bounce%0d level", k), level_out, 4'b0000);
      check($sformatf("bounce%0d rise", k), rise_pulse, 4'b0000);
      check($sformatf("bounce%0d fall", k), fall_pulse, 4'b0000);
    end
    in_raw = 4'b0000;
    repeat (8) tick_sample();
    $display("bounce done level=%b", level_out);
    check("post-bounce level", level_out, 4'b0000);

    // Saturation: bit 2 held for 50 ticks.
    in_raw    = 4'b0100;
    rise_cnt  = 0;
    fall_cnt  = 0;
    dropped   = 0;
    seen_high = 0;
    for (int c = 0; c < 200; c++) begin
      tick_sample();
      if (rise_pulse[2]) rise_cnt++;
      if (fall_pulse[2]) fall_cnt++;
      if (level_out[2]) seen_high = 1;
      else if (seen_high != 0) dropped = 1;
    end
    $display("saturation level=%b rises=%0d falls=%0d", level_out, rise_cnt, fall_cnt);
    check("sat rise count", rise_cnt, 1);
    check("sat fall count", fall_cnt, 0);
    check("sat dropped", dropped, 0);
    check("sat level", level_out, 4'b0100);

    // Reset in the middle of a press on bit 0.
    in_raw = 4'b0001;
    waited = 0;
    while (!level_out[0] && waited < 40) begin
      tick_sample();
      waited++;
    end
    check("midpress level0", level_out[0], 1'b1);
    rst = 1'b1;
    tick_sample();
    rst = 1'b0;
    $display("reset mid-press level=%b rise=%b fall=%b", level_out, rise_pulse, fall_pulse);
    check("midrst level", level_out, 4'b0000);
    check("midrst rise", rise_pulse, 4'b0000);
    check("midrst fall", fall_pulse, 4'b0000);
    for (int c = 1; c <= 12; c++) begin
      tick_sample();
      check($sformatf("repress%0d fall", c), fall_pulse, 4'b0000);
      if (c < 12) begin
        check($sformatf("repress%0d level", c), level_out, 4'b0000);
        check($sformatf("repress%0d rise", c), rise_pulse, 4'b0000);
      end else begin
        check("repress level", level_out, 4'b0001);
        check("repress rise", rise_pulse, 4'b0001);
      end
    end
    $display("re-press level=%b", level_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
